pc_ifid_stage: RTL

Consumer end of the fetch-redirect interface. Holds the program counter, accepts the next-PC and flush (`clr`) decisions produced by the jump/branch predictor, and drives the IF/ID pipeline register that feeds the predictor's ID-stage inputs on the following cycle. It also handles stalls from the hazard unit, end-of-program halting, and counts flush and stall cycles for performance analysis.

---
 rtl/pc_ifid_stage_pkg.sv | 34 +++
 rtl/pc_ifid_stage_sat_counter.sv | 23 ++
 rtl/pc_ifid_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/pc_ifid_stage_pkg.sv
// Shared definitions for the fetch stage: bubble word, RUN/HALT encoding,
// counter width and the IF/ID register layout.
package pc_ifid_stage_pkg;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.pc    = 32'h0000_0000;
    b.ins   = NOP_INS;
    b.valid = 1'b0;
    return b;
  endfunction

  function automatic ifid_t ifid_fill(input logic [31:0] pc, input logic [31:0] ins);
    ifid_t f;
    f.pc    = pc;
    f.ins   = ins;
    f.valid = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/pc_ifid_stage_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pc_ifid_stage.sv
// Program counter and IF/ID pipeline register at the consumer end of the
// fetch-redirect path, with end-of-program halt and flush/stall counters.
module pc_ifid_stage
  import pc_ifid_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        clr,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic [31:0] id_pc,
  output logic [31:0] id_ins,
  output logic        id_valid,
  output logic        halted,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
);

  logic [31:0] pc_reg, pc_next;
  ifid_t       ifid_reg, ifid_next;
  logic        state_reg, state_next;
  logic        flush_inc, stall_inc;
  logic        at_end;

  assign at_end = (pc_reg >= MAX_INSADDR);

  // npc is only selected on a flush or a normal RUN advance, so an X on npc
  // at the end of the program never reaches a register.
  always_comb begin
    pc_next    = pc_reg;
    ifid_next  = ifid_reg;
    state_next = state_reg;
    flush_inc  = 1'b0;
    stall_inc  = 1'b0;
    if (clr) begin
      pc_next    = npc;
      ifid_next  = ifid_bubble();
      state_next = RUN;
      flush_inc  = 1'b1;
    end else if (stall) begin
      stall_inc = 1'b1;
    end else if (state_reg == HALT) begin
      ifid_next = ifid_bubble();
    end else if (at_end) begin
      ifid_next  = ifid_fill(pc_reg, imem_rdata);
      state_next = HALT;
    end else begin
      pc_next   = npc;
      ifid_next = ifid_fill(pc_reg, imem_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      ifid_reg  <= ifid_bubble();
      state_reg <= RUN;
    end else begin
      pc_reg    <= pc_next;
      ifid_reg  <= ifid_next;
      state_reg <= state_next;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  assign pc       = pc_reg;
  assign ins      = (state_reg == HALT) ? NOP_INS : imem_rdata;
  assign id_pc    = ifid_reg.pc;
  assign id_ins   = ifid_reg.ins;
  assign id_valid = ifid_reg.valid;
  assign halted   = (state_reg == HALT);

endmodule
